// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction-fetch stage.
//   ILEN             : instruction / address width.
//   DEFAULT_RESET_PC : default program-counter value after reset.
//   NOP              : canonical RISC-V no-op (addi x0, x0, 0).
//   fetch_entry_t    : one fetched word tagged with the PC it came from.
package fetch_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue -- small circular FIFO of fetched {pc, inst} entries.
//   clk, rst_n : clock, asynchronous active-low reset.
//   push       : write push_data this cycle (ignored when full with no pop).
//   push_data  : entry to write.
//   pop        : consume the head this cycle (ignored when empty).
//   flush      : drop every entry; wins over push and pop.
//   valid      : queue holds at least one entry.
//   head       : oldest entry; while empty it keeps showing the last head.
//   count      : occupancy, 0..DEPTH.
// DEPTH must be a power of two (pointers wrap by overflow) and at least 2.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         valid,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  fetch_entry_t   hold_q;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // NOTE: storage has no reset -- occupancy is tracked by count, so stale
  // contents are never observed and the array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Remember whatever head was last presented so the outputs stay put once
  // the queue drains or is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (valid) begin
      hold_q <= mem[rd_ptr];
    end
  end

  assign head = valid ? mem[rd_ptr] : hold_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage: owns the PC, drives the
// combinational instruction memory and queues {pc, inst} for decode.
//   clk, rst_n      : clock, asynchronous active-low reset.
//   ce, addr        : instruction-memory enable and byte address (addr == pc).
//   inst            : word returned by memory in the same cycle.
//   redirect_valid  : execute requests a PC change; flushes the queue.
//   redirect_pc     : redirect target.
//   id_valid/ready  : handshake to decode; id_inst/id_pc carry the head.
//   fetch_exc(_pc)  : sticky misaligned-target flag and offending target,
//                     present only when FETCH_MISALIGN_TRAP_EN is defined.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ce,
  output logic [ILEN-1:0] addr,
  input  logic [ILEN-1:0] inst,
  input  logic            redirect_valid,
  input  logic [ILEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_inst,
  output logic [ILEN-1:0] id_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_exc,
  output logic [ILEN-1:0] fetch_exc_pc
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ILEN-1:0] pc;
  logic            run;
  logic [CW-1:0]   count;
  logic            q_valid;
  fetch_entry_t    q_head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            stall;
  logic [ILEN-1:0] redirect_target;

  assign pop = q_valid & id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_target = redirect_pc;
  assign stall           = fetch_exc;
`else
  // Low bits are dropped, so a misaligned target silently rounds down.
  assign redirect_target = redirect_pc & ~32'h0000_0003;
  assign stall           = 1'b0;
`endif

  // A same-cycle pop frees a slot, so a full queue keeps streaming.
  assign ce = run & ~redirect_valid & ~stall & ((count < CW'(DEPTH)) | pop);

  assign addr       = pc;
  assign push_entry = '{pc: pc, inst: inst};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        pc <= redirect_target;
      end else if (ce) begin
        pc <= pc + 32'd4;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky until a redirect to an aligned target; the offending target is
  // kept for the trap handler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_exc    <= 1'b0;
      fetch_exc_pc <= '0;
    end else if (redirect_valid) begin
      fetch_exc <= (redirect_pc[1:0] != 2'b00);
      if (redirect_pc[1:0] != 2'b00) begin
        fetch_exc_pc <= redirect_pc;
      end
    end
  end
`endif

  // A redirect discards any same-cycle pop: the whole queue is wrong-path.
  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ce),
    .push_data (push_entry),
    .pop       (pop & ~redirect_valid),
    .flush     (redirect_valid),
    .valid     (q_valid),
    .head      (q_head),
    .count     (count)
  );

  assign id_valid = q_valid;
  assign id_pc    = q_head.pc;
  assign id_inst  = q_head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit. A queue-based
// reference model predicts ce/addr/id_* (and the exception outputs when
// FETCH_MISALIGN_TRAP_EN is defined) every cycle under directed and random
// stimulus.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_exc;
  logic [31:0] fetch_exc_pc;
`endif

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ce             (ce),
    .addr           (addr),
    .inst           (inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_exc      (fetch_exc),
    .fetch_exc_pc   (fetch_exc_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: every address returns a distinct, deterministic word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  assign inst = mem_word(addr);

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the fetch queue is an ordinary SV queue.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_run;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_inst;
  bit          m_exc;
  logic [31:0] m_exc_pc;

  task automatic model_reset();
    mq.delete();
    m_pc        = RESET_PC;
    m_run       = 1'b0;
    m_last_pc   = '0;
    m_last_inst = '0;
    m_exc       = 1'b0;
    m_exc_pc    = '0;
  endtask

  // Called at a falling edge: drive inputs, compare, advance the model, and
  // return at the next falling edge.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit          e_valid;
    bit          e_pop;
    bit          e_ce;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    #1;
    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc   : m_last_pc;
    e_inst  = e_valid ? mq[0].inst : m_last_inst;
    e_pop   = e_valid && rdy;
    e_ce    = m_run && !rv && !m_exc && ((mq.size() < DEPTH) || e_pop);
    check("ce",       32'(ce),       32'(e_ce));
    check("addr",     addr,          m_pc);
    check("id_valid", 32'(id_valid), 32'(e_valid));
    check("id_pc",    id_pc,         e_pc);
    check("id_inst",  id_inst,       e_inst);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("fetch_exc",    32'(fetch_exc), 32'(m_exc));
    check("fetch_exc_pc", fetch_exc_pc,   m_exc_pc);
`endif
    if (e_valid) begin
      m_last_pc   = e_pc;
      m_last_inst = e_inst;
    end
    if (rv) begin
      mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc  = rpc;
      m_exc = (rpc % 4) != 0;
      if (m_exc) m_exc_pc = rpc;
`else
      m_pc = rpc - (rpc % 4);
`endif
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_ce) begin
        mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    model_reset();

    // Reset values.
    #3;
    check("rst_ce",       32'(ce),       32'd0);
    check("rst_addr",     addr,          RESET_PC);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc",    id_pc,         32'd0);
    check("rst_id_inst",  id_inst,       32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Start-up and streaming: ce first in cycle 2, then 0x0, 0x4, 0x8 ...
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Back-pressure fills the queue; pc must hold; then drain in order.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Redirect with a full queue and decode ready.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // PC wrap-around at the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Misaligned target: traps with the macro, rounds down without it.
    step(1'b1, 32'h0000_0102, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Random traffic: sporadic back-pressure and redirects.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, 32'($urandom_range(0, 65535)),
           $urandom_range(0, 3) != 0);
    end
    step(1'b1, 32'h0000_0040, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Asynchronous reset while the queue is full, away from any edge.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_id_valid", 32'(id_valid), 32'd0);
    check("arst_addr",     addr,          RESET_PC);
    check("arst_ce",       32'(ce),       32'd0);
    check("arst_id_pc",    id_pc,         32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
